// File: rtl/shiftreg_updown_counter.sv
// Serial/parallel loadable WIDTH-bit register that counts up or down once loaded,
// with wrap or saturate at the limits and zero / terminal-count / full flags.
module shiftreg_updown_counter #(
  parameter int                WIDTH     = 4,
  parameter bit                WRAP      = 1'b1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_ena,
  input  logic             d,
  input  logic             count_ena,
  input  logic             count_up,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             tc,
  output logic             full
);

  localparam int               CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CMAX = CW'(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [CW-1:0]    shift_cnt;
  logic [CW-1:0]    shift_cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_nxt;

  // One operation per edge, in priority order load > shift > count > hold.
  always_comb begin
    q_nxt         = q;
    shift_cnt_nxt = shift_cnt;
    tc_nxt        = 1'b0;
    if (load) begin
      q_nxt         = load_data;
      shift_cnt_nxt = '0;
    end else if (shift_ena) begin
      q_nxt = {q[WIDTH-2:0], d};
      if (shift_cnt != CMAX) shift_cnt_nxt = shift_cnt + CW'(1);
    end else if (count_ena) begin
      if (count_up) begin
        if (q != ONES) begin
          q_nxt  = q + ONE;
          tc_nxt = (q == ONES - ONE);
        end else if (WRAP) begin
          q_nxt = '0;
        end
      end else begin
        // Only a real step into the terminal value pulses tc; wraps and saturated holds do not.
        if (q != '0) begin
          q_nxt  = q - ONE;
          tc_nxt = (q == ONE);
        end else if (WRAP) begin
          q_nxt = ONES;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      tc        <= 1'b0;
    end else begin
      q         <= q_nxt;
      shift_cnt <= shift_cnt_nxt;
      tc        <= tc_nxt;
    end
  end

  assign zero = (q == '0);
  assign full = (shift_cnt == CMAX);

endmodule

// File: tb/tb_shiftreg_updown_counter.sv
// Directed bench for shiftreg_updown_counter: three instances share stimulus
// (default, RESET_VAL=5, WRAP=0) and each step checks the instance of interest.
module tb_shiftreg_updown_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] load_data;
  logic       shift_ena;
  logic       d;
  logic       count_ena;
  logic       count_up;

  logic [3:0] q_a, q_b, q_c;
  logic       zero_a, zero_b, zero_c;
  logic       tc_a, tc_b, tc_c;
  logic       full_a, full_b, full_c;

  int tests;
  int fails;

  shiftreg_updown_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'h0)) dut_a (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .shift_ena(shift_ena), .d(d), .count_ena(count_ena), .count_up(count_up),
    .q(q_a), .zero(zero_a), .tc(tc_a), .full(full_a)
  );

  shiftreg_updown_counter #(.WIDTH(4), .WRAP(1'b1), .RESET_VAL(4'h5)) dut_b (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .shift_ena(shift_ena), .d(d), .count_ena(count_ena), .count_up(count_up),
    .q(q_b), .zero(zero_b), .tc(tc_b), .full(full_b)
  );

  shiftreg_updown_counter #(.WIDTH(4), .WRAP(1'b0), .RESET_VAL(4'h0)) dut_c (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .shift_ena(shift_ena), .d(d), .count_ena(count_ena), .count_up(count_up),
    .q(q_c), .zero(zero_c), .tc(tc_c), .full(full_c)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    load = 1'b0; shift_ena = 1'b0; count_ena = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    idle(); load = 1'b1; load_data = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_shift(input logic bit_in);
    idle(); shift_ena = 1'b1; d = bit_in;
    step();
    shift_ena = 1'b0;
  endtask

  task automatic do_count(input logic up);
    idle(); count_ena = 1'b1; count_up = up;
    step();
    count_ena = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; load = 1'b0; load_data = 4'h0; shift_ena = 1'b0;
    d = 1'b0; count_ena = 1'b0; count_up = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check4("rst_q_a", q_a, 4'h0);
    check4("rst_q_b", q_b, 4'h5);
    check1("rst_zero_a", zero_a, 1'b1);
    check1("rst_zero_b", zero_b, 1'b0);
    check1("rst_tc_a", tc_a, 1'b0);
    check1("rst_full_a", full_a, 1'b0);

    // Async reset between edges
    do_load(4'hA);
    check4("load_a_b", q_b, 4'hA);
    #3 rst = 1'b1;
    #1;
    check4("async_q_b", q_b, 4'h5);
    check1("async_tc_b", tc_b, 1'b0);
    check1("async_full_b", full_b, 1'b0);
    step();
    check4("rst_held_q_b", q_b, 4'h5);
    rst = 1'b0;

    // Serial load 1,1,0,1 then 0
    do_shift(1'b1);
    check4("sh1_q", q_a, 4'h1); check1("sh1_full", full_a, 1'b0);
    do_shift(1'b1);
    check4("sh2_q", q_a, 4'h3); check1("sh2_full", full_a, 1'b0);
    do_shift(1'b0);
    check4("sh3_q", q_a, 4'h6); check1("sh3_full", full_a, 1'b0);
    do_shift(1'b1);
    check4("sh4_q", q_a, 4'hD); check1("sh4_full", full_a, 1'b1);
    do_shift(1'b0);
    check4("sh5_q", q_a, 4'hA); check1("sh5_full", full_a, 1'b1);

    // Counting leaves full alone; hold keeps q
    do_count(1'b1);
    check4("cnt_full_q", q_a, 4'hB); check1("cnt_full_full", full_a, 1'b1);
    step();
    check4("hold_q", q_a, 4'hB); check1("hold_tc", tc_a, 1'b0);

    // Down count with wrap
    do_load(4'h3);
    check1("dn_load_full", full_a, 1'b0);
    check1("dn_load_tc", tc_a, 1'b0);
    do_count(1'b0);
    check4("dn1_q", q_a, 4'h2); check1("dn1_tc", tc_a, 1'b0); check1("dn1_zero", zero_a, 1'b0);
    do_count(1'b0);
    check4("dn2_q", q_a, 4'h1); check1("dn2_tc", tc_a, 1'b0); check1("dn2_zero", zero_a, 1'b0);
    do_count(1'b0);
    check4("dn3_q", q_a, 4'h0); check1("dn3_tc", tc_a, 1'b1); check1("dn3_zero", zero_a, 1'b1);
    do_count(1'b0);
    check4("dn4_q", q_a, 4'hF); check1("dn4_tc", tc_a, 1'b0); check1("dn4_zero", zero_a, 1'b0);

    // Down saturation on WRAP=0 instance
    do_load(4'h1);
    do_count(1'b0);
    check4("sat1_q", q_c, 4'h0); check1("sat1_tc", tc_c, 1'b1); check1("sat1_zero", zero_c, 1'b1);
    do_count(1'b0);
    check4("sat2_q", q_c, 4'h0); check1("sat2_tc", tc_c, 1'b0); check1("sat2_zero", zero_c, 1'b1);
    do_count(1'b0);
    check4("sat3_q", q_c, 4'h0); check1("sat3_tc", tc_c, 1'b0); check1("sat3_zero", zero_c, 1'b1);

    // Up count: wrap on a, saturate on c
    do_load(4'hE);
    do_count(1'b1);
    check4("up1_q_a", q_a, 4'hF); check1("up1_tc_a", tc_a, 1'b1);
    check4("up1_q_c", q_c, 4'hF); check1("up1_tc_c", tc_c, 1'b1);
    do_count(1'b1);
    check4("up2_q_a", q_a, 4'h0); check1("up2_tc_a", tc_a, 1'b0);
    check4("up2_q_c", q_c, 4'hF); check1("up2_tc_c", tc_c, 1'b0);

    // Terminal value reached by load gives no tc
    do_load(4'h0);
    check1("load_term_tc", tc_a, 1'b0);

    // Priority: load over shift and count, clears full
    do_shift(1'b1); do_shift(1'b1); do_shift(1'b1); do_shift(1'b1);
    check1("pri_pre_full", full_a, 1'b1);
    load = 1'b1; shift_ena = 1'b1; count_ena = 1'b1; count_up = 1'b1; load_data = 4'h9; d = 1'b1;
    step();
    check4("pri_load_q", q_a, 4'h9); check1("pri_load_full", full_a, 1'b0);
    load = 1'b0; d = 1'b0;
    step();
    check4("pri_shift_q", q_a, 4'h2); check1("pri_shift_tc", tc_a, 1'b0);
    check1("pri_shift_full", full_a, 1'b0);
    idle();

    // Reset mid-sequence discards the partial shift count
    do_shift(1'b1);
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    do_shift(1'b1); do_shift(1'b1); do_shift(1'b1);
    check1("rst_mid_full", full_a, 1'b0);
    check4("rst_mid_q", q_a, 4'h7);
    do_shift(1'b0);
    check1("rst_mid_full4", full_a, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shiftreg_updown_counter.md
Name: shiftreg_updown_counter

Overview:
Parametrised shift register cum up/down counter; the next generation of the team's 4-bit shift-in/down-count block. It is a serial-loadable, parallel-loadable WIDTH-bit register that can count up or down once loaded, with wrap or saturate at the limits. Flags report zero, terminal count and "WIDTH bits shifted in". It is used as a programmable delay/timer whose start value arrives serially.

Parameters:
WIDTH, 4, register width in bits; legal range WIDTH >= 2.
WRAP, 1, 1 = count wraps at limits; 0 = count saturates at limits.
RESET_VAL, 0, value of q after reset, WIDTH bits wide.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, asynchronous, active-high.
load  input  1  parallel load enable.
load_data  input  WIDTH  parallel load value.
shift_ena  input  1  shift enable.
d  input  1  serial data in.
count_ena  input  1  count enable.
count_up  input  1  1 = increment, 0 = decrement; sampled only when a count step occurs.
q  output  WIDTH  register contents.
zero  output  1  combinational; 1 when q == 0.
tc  output  1  registered one-cycle terminal-count pulse.
full  output  1  1 once WIDTH shifts have occurred since the last reset or load.

Behaviour:
- Clocking and reset: one clock domain, clk. rst is asynchronous and active-high.
- While rst = 1: q = RESET_VAL, tc = 0, full = 0, and the internal shift count = 0, all immediately and asynchronously.
- Deassertion of rst takes effect at the next clk edge. Reset in the middle of a shift or count sequence abandons it with no residual state.
- Per-edge operation priority: load > shift_ena > count_ena > hold. Exactly one operation executes per edge.
- LOAD: q <= load_data; shift count <= 0.
- SHIFT: q <= {q[WIDTH-2:0], d}. d enters the LSB; after N shifts the first bit shifted in sits at bit N-1. Shift count increments and saturates at WIDTH.
- COUNT, down (count_up = 0):
  - q != 0: q <= q-1.
  - q == 0 and WRAP = 1: q <= all-ones.
  - q == 0 and WRAP = 0: q holds at 0.
- COUNT, up (count_up = 1):
  - q != all-ones: q <= q+1.
  - q == all-ones and WRAP = 1: q <= 0.
  - q == all-ones and WRAP = 0: q holds at all-ones.
- Count arithmetic is modulo 2^WIDTH and unsigned. Counting does not change the shift count.
- HOLD: all state unchanged.
- tc: on each edge, tc <= 1 only if a COUNT step executed and changed q to the terminal value (0 for down, all-ones for up).
  - Otherwise tc <= 0, so tc is a single-cycle pulse visible in the cycle after q reaches the terminal value.
  - A saturated hold at the terminal value gives no tc.
  - A wrap away from terminal (0 -> all-ones when down) gives no tc.
  - Reaching the terminal value by LOAD or SHIFT gives no tc.
- full = (shift count == WIDTH). It is derived from registered state, so no combinational path from the inputs. It clears on LOAD or reset and is unaffected by COUNT.
- zero is combinational from q only.
- Shift-count register width is $clog2(WIDTH+1) bits. No X may reach any output after reset.

Test Plan:
1. Asynchronous reset (WIDTH=4, RESET_VAL=4'h5): set q=4'hA via load, then raise rst between clock edges -> q=4'h5, tc=0, full=0 before the next edge; q stays 5 while rst is held.
2. Serial load: after reset (RESET_VAL=0), shift_ena=1 for 4 edges with d=1,1,0,1 -> q=4'b1101 and full=1 after edge 4 (full=0 after edges 1-3). A 5th shift with d=0 -> q=4'b1010, full stays 1.
3. Down count, WRAP=1: load 4'h3, count_ena=1, count_up=0 -> q=2,1,0,F. tc=1 only in the cycle after q becomes 0; zero=1 only while q=0.
4. Saturation, WRAP=0: load 4'h1, count down 3 edges -> q=0,0,0; tc pulses once, then stays 0; zero stays 1.
5. Up count, WRAP=1: load 4'hE, count_up=1 -> q=F (tc pulse next cycle), then 0 (no tc). With WRAP=0, q holds at F and gives no second tc.
6. Priority and flag clearing:
   - load=1, shift_ena=1, count_ena=1 with load_data=4'h9 -> q=9 and full clears.
   - shift_ena=1, count_ena=1 from q=9, d=0 -> q=4'b0010 (shift wins), no tc.
